// File: rtl/ula_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, result flags
// and the iteration-counter width helper.
package ula_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CALCULA   = 2'd1,
    CONCLUIDO = 2'd2
  } state_t;

  typedef struct packed {
    logic igual;
    logic menor;
    logic maior_igual_u;
    logic overflow;
  } flags_t;

  // Counter only needs to reach BITS-1; it wraps harmlessly on the final step.
  function automatic int iter_cnt_w(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/ula_mc_iter.sv
// One-bit-per-cycle shift-add multiplier and, when ULA_MC_DIV_EN is defined,
// restoring divider. last_o marks the edge that performs the final step.
module ula_mc_iter
  import ula_mc_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
`ifdef ULA_MC_DIV_EN
  input  logic            div_i,
  input  logic            rem_i,
`endif
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic            last_o,
  output logic [BITS-1:0] result_o
);

  localparam int CW = iter_cnt_w(BITS);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] x_q, x_d;     // multiplier / dividend shifting into quotient
  logic [BITS-1:0] y_q, y_d;     // multiplicand / divisor
  logic [BITS-1:0] acc_q, acc_d; // product / partial remainder
`ifdef ULA_MC_DIV_EN
  logic            div_q, div_d, rem_q, rem_d;
  logic [BITS:0]   rem_sh;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    last_o = busy_q && (cnt_q == CW'(BITS - 1));
`ifdef ULA_MC_DIV_EN
    div_d  = div_q;
    rem_d  = rem_q;
    rem_sh = {acc_q, x_q[BITS-1]};
`endif
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      x_d    = a_i;
      y_d    = b_i;
      acc_d  = '0;
`ifdef ULA_MC_DIV_EN
      div_d  = div_i;
      rem_d  = rem_i;
`endif
    end else if (busy_q) begin
      cnt_d  = cnt_q + CW'(1);
      busy_d = !last_o;
`ifdef ULA_MC_DIV_EN
      if (div_q) begin
        // A zero divisor always "fits", yielding all-ones quotient and the dividend as remainder.
        if (rem_sh >= {1'b0, y_q}) begin
          acc_d = BITS'(rem_sh - {1'b0, y_q});
          x_d   = {x_q[BITS-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[BITS-1:0];
          x_d   = {x_q[BITS-2:0], 1'b0};
        end
      end else
`endif
      begin
        acc_d = acc_q + (x_q[0] ? y_q : '0);
        x_d   = x_q >> 1;
        y_d   = y_q << 1;
      end
    end
`ifdef ULA_MC_DIV_EN
    result_o = (div_q && !rem_q) ? x_d : acc_d;
`else
    result_o = acc_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
`ifdef ULA_MC_DIV_EN
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      acc_q  <= acc_d;
`ifdef ULA_MC_DIV_EN
      div_q  <= div_d;
      rem_q  <= rem_d;
`endif
    end
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU with valid/ready handshake. Single-cycle ops live here; MUL
// (and DIVU/REMU when ULA_MC_DIV_EN is defined) iterate in ula_mc_iter.
module ula_mc
  import ula_mc_pkg::*;
#(
  parameter int BITS = 64,
  parameter int SHW  = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] dina,
  input  logic [BITS-1:0] dinb,
  input  logic [BITS-1:0] imm,
  input  logic            alu_src,
  input  logic [3:0]      operacao,
  input  logic            entrada_valida,
  output logic            ocupado,
  output logic            saida_valida,
  input  logic            saida_pronta,
  output logic [BITS-1:0] dout,
  output logic            flag_igual,
  output logic            flag_menor,
  output logic            flag_maior_igual_u,
  output logic            flag_overflow
);

  state_t          state_q, state_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d, dout_q, dout_d;
  logic [3:0]      op_q, op_d;
  flags_t          flags_q, flags_d;

  logic [BITS-1:0] op_a, op_b, alu_res, sum, diff, iter_res;
  logic [3:0]      op_sel;
  logic [SHW-1:0]  shamt;
  flags_t          alu_flags;
  logic            is_iter, iter_start, iter_last;

  // While idle the ALU sees the live request; afterwards it sees the captured one.
  assign op_a   = (state_q == OCIOSO) ? dina : a_q;
  assign op_b   = (state_q == OCIOSO) ? (alu_src ? imm : dinb) : b_q;
  assign op_sel = (state_q == OCIOSO) ? operacao : op_q;
  assign shamt  = op_b[SHW-1:0];
  assign sum    = op_a + op_b;
  assign diff   = op_a + ~op_b + BITS'(1);

`ifdef ULA_MC_DIV_EN
  assign is_iter = (op_sel == OP_MUL) || (op_sel == OP_DIVU) || (op_sel == OP_REMU);
`else
  assign is_iter = (op_sel == OP_MUL);
`endif

  always_comb begin
    alu_res                 = '0;
    alu_flags               = '0;
    alu_flags.igual         = (op_a == op_b);
    alu_flags.menor         = ($signed(op_a) < $signed(op_b));
    alu_flags.maior_igual_u = (op_a >= op_b);
    case (op_sel)
      OP_ADD: begin
        alu_res            = sum;
        alu_flags.overflow = (op_a[BITS-1] == op_b[BITS-1]) && (sum[BITS-1] != op_a[BITS-1]);
      end
      OP_SUB: begin
        alu_res            = diff;
        alu_flags.overflow = (op_a[BITS-1] != op_b[BITS-1]) && (diff[BITS-1] != op_a[BITS-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = BITS'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = BITS'(op_a < op_b);
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_MUL:  alu_res = '0;
`ifdef ULA_MC_DIV_EN
      OP_DIVU, OP_REMU: alu_res = '0;
`endif
      default: alu_flags = '0;
    endcase
  end

  ula_mc_iter #(.BITS(BITS)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
`ifdef ULA_MC_DIV_EN
    .div_i    (op_sel != OP_MUL),
    .rem_i    (op_sel == OP_REMU),
`endif
    .a_i      (op_a),
    .b_i      (op_b),
    .last_o   (iter_last),
    .result_o (iter_res)
  );

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    flags_d    = flags_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    iter_start = 1'b0;
    unique case (state_q)
      OCIOSO: if (entrada_valida) begin
        a_d  = op_a;
        b_d  = op_b;
        op_d = op_sel;
        if (is_iter) begin
          iter_start = 1'b1;
          state_d    = CALCULA;
        end else begin
          dout_d  = alu_res;
          flags_d = alu_flags;
          state_d = CONCLUIDO;
        end
      end
      CALCULA: if (iter_last) begin
        dout_d  = iter_res;
        flags_d = alu_flags;
        state_d = CONCLUIDO;
      end
      CONCLUIDO: if (saida_pronta) state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: captured operands are reset too, so the flag logic never sees X after reset.
    if (!rst_n) begin
      state_q <= OCIOSO;
      dout_q  <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      flags_q <= flags_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign ocupado            = (state_q != OCIOSO);
  assign saida_valida       = (state_q == CONCLUIDO);
  assign dout               = dout_q;
  assign flag_igual         = flags_q.igual;
  assign flag_menor         = flags_q.menor;
  assign flag_maior_igual_u = flags_q.maior_igual_u;
  assign flag_overflow      = flags_q.overflow;

endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 Parameter BITS, default 64, datapath width; legal values 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(BITS), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dina  input  BITS  operand A.
REQ-006 dinb  input  BITS  operand B, register source.
REQ-007 imm  input  BITS  operand B, immediate source.
REQ-008 alu_src  input  1  1 selects imm as operand B, 0 selects dinb.
REQ-009 operacao  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 DIVU, 12 REMU.
REQ-010 entrada_valida  input  1  request valid.
REQ-011 ocupado  output  1  unit cannot accept a request.
REQ-012 saida_valida  output  1  dout and flags hold a valid result.
REQ-013 saida_pronta  input  1  consumer accepts the result.
REQ-014 dout  output  BITS  registered result.
REQ-015 flag_igual, flag_menor, flag_maior_igual_u, flag_overflow  output  1 each  registered flags.

Function
REQ-016 The unit SHALL accept a request on a rising edge where entrada_valida=1 and ocupado=0, capturing dina, selected operand B and operacao.
REQ-017 The FSM SHALL use states OCIOSO, CALCULA and CONCLUIDO; ocupado SHALL be 1 in CALCULA and CONCLUIDO.
REQ-018 Opcodes 0-9 SHALL go from OCIOSO directly to CONCLUIDO, with saida_valida=1 one cycle after acceptance.
REQ-019 MUL SHALL use shift-add iteration, one bit per cycle, for BITS cycles in CALCULA, giving saida_valida=1 exactly BITS+1 cycles after acceptance; dout SHALL be the low BITS of the product.
REQ-020 CONCLUIDO SHALL hold dout and flags stable until saida_pronta=1, then return to OCIOSO on that edge.
REQ-021 A request SHALL NOT be accepted on the same edge a result is consumed; the earliest following acceptance is one cycle later.
REQ-022 SUB SHALL compute A + ~B + 1; flag_overflow SHALL be the signed overflow for ADD/SUB and 0 for all other ops.
REQ-023 flag_igual, flag_menor (signed) and flag_maior_igual_u (unsigned) SHALL compare the captured A and B for every opcode.
REQ-024 SLT and SLTU SHALL return 1 or 0 zero-extended to BITS.
REQ-025 Shifts SHALL use only B[SHW-1:0]; SRA SHALL sign-extend.
REQ-026 Opcodes 13-15, and 11-12 when division is excluded, SHALL complete in one cycle with dout=0 and all flags 0.
REQ-027 Inputs SHALL be ignored while ocupado=1; saida_pronta SHALL be ignored outside CONCLUIDO.

Reset
REQ-028 rst_n=0 SHALL immediately force state OCIOSO, ocupado=0, saida_valida=0, dout=0 and all flags 0, including during CALCULA, and SHALL abort any iteration in progress.
REQ-029 The first request SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-030 With macro ULA_MC_DIV_EN defined, DIVU and REMU SHALL use restoring division, one bit per cycle, with the same BITS+1 latency as MUL.
REQ-031 With ULA_MC_DIV_EN defined, divide by zero SHALL return all ones for DIVU and the dividend for REMU, with no trap and with the normal latency.
REQ-032 Without ULA_MC_DIV_EN, no divider logic SHALL be synthesised and opcodes 11-12 SHALL follow REQ-026.

Structure
REQ-033 A shared package ula_mc_pkg SHALL hold the opcode constants, the FSM state encoding, and the shared iteration-counter width function.
REQ-034 The iterative multiply/divide datapath SHALL be the single sub-module ula_mc_iter; the single-cycle ops remain in ula_mc.

Verification
REQ-035 BITS=8: ADD, A=0x7F, B=0x01, alu_src=0 -> after 1 cycle dout=0x80, flag_overflow=1, saida_valida=1.
REQ-036 BITS=8: SUB, A=0x05, imm=0x05, alu_src=1 -> dout=0x00, flag_igual=1, flag_overflow=0; SRA with A=0x80, B=0x0B -> dout=0xF0 (shift 3).
REQ-037 BITS=8: MUL, A=0x0D, B=0x0B -> saida_valida rises exactly 9 cycles after acceptance, dout=0x8F, ocupado=1 throughout.
REQ-038 Backpressure: saida_pronta held 0 for 5 cycles after a result -> dout stable and a new entrada_valida ignored; saida_pronta=1 -> OCIOSO, next request accepted one cycle later.
REQ-039 rst_n pulsed low at cycle 4 of a MUL -> outputs cleared asynchronously; a following ADD 0x02+0x03 -> dout=0x05.
REQ-040 With ULA_MC_DIV_EN, BITS=8: DIVU 0x64/0x07 -> 0x0E; REMU 0x64/0x07 -> 0x02; DIVU x/0 -> 0xFF. Without the macro, DIVU -> dout=0 after 1 cycle.
